// File: rtl/sy_pkg.sv
// Shared defaults and entry layout for the sy_ppl CSR issue queue.
// Optional bypass build: SY_CSR_IQ_BYPASS_EN.
package sy_pkg;

  localparam int CSR_IQ_DEPTH   = 4;
  localparam int CSR_IQ_N_AWAKE = 5;
  localparam int CSR_IQ_IDX_WTH = $clog2(CSR_IQ_DEPTH);
  localparam int CSR_CADDR_WTH  = 12;
  localparam int CSR_PREG_WTH   = 7;
  localparam int CSR_PLD_WTH    = 32;

  typedef struct packed {
    logic [CSR_CADDR_WTH-1:0]  addr;
    logic                      rd_en;
    logic                      wr_en;
    logic [CSR_PREG_WTH-1:0]   rs1_idx;
    logic                      rs1_rdy;
    logic                      raw_en;
    logic [CSR_IQ_IDX_WTH-1:0] raw_idx;
    logic                      wd_vld;
    logic [CSR_PLD_WTH-1:0]    pld;
  } csr_iq_ent_t;

endpackage

// File: rtl/sy_ppl_csr_iq_wakeup.sv
// Matches one rs1 index against every integer wakeup channel.
// FP-file wakeups never match.
module sy_ppl_csr_iq_wakeup #(
  parameter int N_AWAKE  = 5,
  parameter int PREG_WTH = 7
) (
  input  logic [PREG_WTH-1:0]         rs1_idx_i,
  input  logic [N_AWAKE-1:0]          awake_vld_i,
  input  logic [N_AWAKE*PREG_WTH-1:0] awake_idx_i,
  input  logic [N_AWAKE-1:0]          awake_is_fp_i,
  output logic                        match_o
);

  always_comb begin
    match_o = 1'b0;
    for (int k = 0; k < N_AWAKE; k++) begin
      if (awake_vld_i[k] && !awake_is_fp_i[k] &&
          awake_idx_i[k*PREG_WTH +: PREG_WTH] == rs1_idx_i)
        match_o = 1'b1;
    end
  end

endmodule

// File: rtl/sy_ppl_csr_iq_gen.sv
// In-order CSR issue queue: rs1 wakeup, CSR RAW tracking, in-order commit.
// Define SY_CSR_IQ_BYPASS_EN to let RAW-blocked ops issue on producer data.
module sy_ppl_csr_iq_gen
  import sy_pkg::*;
#(
  parameter int DEPTH     = CSR_IQ_DEPTH,
  parameter int IDX_WTH   = $clog2(DEPTH),
  parameter int DWTH      = 64,
  parameter int CADDR_WTH = CSR_CADDR_WTH,
  parameter int PREG_WTH  = CSR_PREG_WTH,
  parameter int N_AWAKE   = CSR_IQ_N_AWAKE,
  parameter int PLD_WTH   = CSR_PLD_WTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        dis_vld_i,
  output logic                        dis_rdy_o,
  input  logic [CADDR_WTH-1:0]        dis_addr_i,
  input  logic                        dis_rd_en_i,
  input  logic                        dis_wr_en_i,
  input  logic [PREG_WTH-1:0]         dis_rs1_idx_i,
  input  logic                        dis_rs1_rdy_i,
  input  logic [PLD_WTH-1:0]          dis_pld_i,
  input  logic [N_AWAKE-1:0]          awake_vld_i,
  input  logic [N_AWAKE*PREG_WTH-1:0] awake_idx_i,
  input  logic [N_AWAKE-1:0]          awake_is_fp_i,
  output logic                        issue_vld_o,
  input  logic                        issue_rdy_i,
  output logic [IDX_WTH-1:0]          issue_idx_o,
  output logic [CADDR_WTH-1:0]        issue_addr_o,
  output logic [PLD_WTH-1:0]          issue_pld_o,
`ifdef SY_CSR_IQ_BYPASS_EN
  output logic                        issue_fwd_vld_o,
  output logic [DWTH-1:0]             issue_fwd_data_o,
`endif
  input  logic                        wd_en_i,
  input  logic [IDX_WTH-1:0]          wd_idx_i,
  input  logic [DWTH-1:0]             wd_data_i,
  input  logic                        retire_i,
  output logic                        rf_wr_en_o,
  output logic [CADDR_WTH-1:0]        rf_waddr_o,
  output logic [DWTH-1:0]             rf_wdata_o,
  output logic [IDX_WTH:0]            cnt_o,
  output logic                        err_o
);

  localparam int PW = IDX_WTH + 1;

  logic [PW-1:0]    ins_q, ins_d, iss_q, iss_d, del_q, del_d;
  csr_iq_ent_t      ent_q [DEPTH];
  csr_iq_ent_t      ent_d [DEPTH];
  logic [DWTH-1:0]  wdata_q [DEPTH];
  logic [DWTH-1:0]  wdata_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             err_q, err_d;

  logic [IDX_WTH-1:0] ins_idx, iss_idx, del_idx;
  logic               full, empty, iss_empty;
  logic [DEPTH-1:0]   ent_wake;
  logic               dis_wake;
  csr_iq_ent_t        iss_ent, del_ent;
  logic               raw_ok, ret_err, ret_ok, ins_fire, wd_err;
  logic               raw_hit;
  logic [IDX_WTH-1:0] raw_idx, slot;

  assign ins_idx   = ins_q[IDX_WTH-1:0];
  assign iss_idx   = iss_q[IDX_WTH-1:0];
  assign del_idx   = del_q[IDX_WTH-1:0];
  assign full      = ({~del_q[IDX_WTH], del_idx} == ins_q);
  assign empty     = (del_q == ins_q);
  assign iss_empty = (iss_q == ins_q);
  assign cnt_o     = ins_q - del_q;
  assign err_o     = err_q;
  assign dis_rdy_o = ~full;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wk
    sy_ppl_csr_iq_wakeup #(
      .N_AWAKE  (N_AWAKE),
      .PREG_WTH (PREG_WTH)
    ) u_wk (
      .rs1_idx_i     (ent_q[g].rs1_idx),
      .awake_vld_i   (awake_vld_i),
      .awake_idx_i   (awake_idx_i),
      .awake_is_fp_i (awake_is_fp_i),
      .match_o       (ent_wake[g])
    );
  end

  sy_ppl_csr_iq_wakeup #(
    .N_AWAKE  (N_AWAKE),
    .PREG_WTH (PREG_WTH)
  ) u_dis_wk (
    .rs1_idx_i     (dis_rs1_idx_i),
    .awake_vld_i   (awake_vld_i),
    .awake_idx_i   (awake_idx_i),
    .awake_is_fp_i (awake_is_fp_i),
    .match_o       (dis_wake)
  );

  assign iss_ent = ent_q[iss_idx];
  assign del_ent = ent_q[del_idx];

`ifdef SY_CSR_IQ_BYPASS_EN
  assign raw_ok = !iss_ent.raw_en ||
                  ent_q[iss_ent.raw_idx].wd_vld;
  assign issue_fwd_vld_o  = issue_vld_o && iss_ent.raw_en;
  assign issue_fwd_data_o = wdata_q[iss_ent.raw_idx];
`else
  assign raw_ok = !iss_ent.raw_en;
`endif

  assign issue_vld_o  = !iss_empty && iss_ent.rs1_rdy &&
                        raw_ok && !flush_i;
  assign issue_idx_o  = iss_idx;
  assign issue_addr_o = iss_ent.addr;
  assign issue_pld_o  = iss_ent.pld;

  // An unissued head, missing write data or empty queue is a bad retire.
  assign ret_err = retire_i && (empty || del_q == iss_q ||
                   (del_ent.wr_en && !del_ent.wd_vld));
  assign ret_ok     = retire_i && !ret_err;
  assign rf_wr_en_o = ret_ok && del_ent.wr_en;
  assign rf_waddr_o = del_ent.addr;
  assign rf_wdata_o = wdata_q[del_idx];

  assign ins_fire = dis_vld_i && dis_rdy_o && !flush_i;
  assign wd_err   = wd_en_i && !vld_q[wd_idx_i];

  // Walk oldest to youngest so the last hit is the youngest writer.
  always_comb begin
    raw_hit = 1'b0;
    raw_idx = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = del_idx + IDX_WTH'(i);
      if (PW'(i) < cnt_o && ent_q[slot].wr_en &&
          ent_q[slot].addr == dis_addr_i &&
          !(rf_wr_en_o && slot == del_idx)) begin
        raw_hit = 1'b1;
        raw_idx = slot;
      end
    end
  end

  always_comb begin
    ins_d   = ins_q;
    iss_d   = iss_q;
    del_d   = del_q;
    ent_d   = ent_q;
    wdata_d = wdata_q;
    vld_d   = vld_q;
    err_d   = err_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (vld_q[e] && ent_wake[e])
        ent_d[e].rs1_rdy = 1'b1;
      if (rf_wr_en_o && ent_q[e].raw_en &&
          ent_q[e].raw_idx == del_idx)
        ent_d[e].raw_en = 1'b0;
    end
    if (wd_en_i && vld_q[wd_idx_i]) begin
      wdata_d[wd_idx_i]       = wd_data_i;
      ent_d[wd_idx_i].wd_vld = 1'b1;
    end
    if (issue_vld_o && issue_rdy_i)
      iss_d = iss_q + PW'(1);
    if (ret_ok) begin
      vld_d[del_idx] = 1'b0;
      del_d          = del_q + PW'(1);
    end
    if (ins_fire) begin
      ent_d[ins_idx].addr    = dis_addr_i;
      ent_d[ins_idx].rd_en   = dis_rd_en_i;
      ent_d[ins_idx].wr_en   = dis_wr_en_i;
      ent_d[ins_idx].rs1_idx = dis_rs1_idx_i;
      ent_d[ins_idx].rs1_rdy = dis_rs1_rdy_i | dis_wake;
      ent_d[ins_idx].raw_en  = dis_rd_en_i && raw_hit;
      ent_d[ins_idx].raw_idx = raw_idx;
      ent_d[ins_idx].wd_vld  = 1'b0;
      ent_d[ins_idx].pld     = dis_pld_i;
      vld_d[ins_idx]         = 1'b1;
      ins_d                  = ins_q + PW'(1);
    end
    if (ret_err || wd_err)
      err_d = 1'b1;
    if (flush_i) begin
      ins_d = '0;
      iss_d = '0;
      del_d = '0;
      vld_d = '0;
      for (int e = 0; e < DEPTH; e++)
        ent_d[e].raw_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ins_q <= '0;
      iss_q <= '0;
      del_q <= '0;
      vld_q <= '0;
      err_q <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_q[e]   <= '0;
        wdata_q[e] <= '0;
      end
    end else begin
      ins_q   <= ins_d;
      iss_q   <= iss_d;
      del_q   <= del_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      ent_q   <= ent_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/sy_ppl_csr_iq_gen.md
Name: sy_ppl_csr_iq_gen

Overview:
- Parametrised, next-generation in-order CSR issue queue for the sy_ppl CSR pipe.
- Sits between dispatch and the CSR execute unit.
- Tracks rs1 readiness across N generic wakeup channels and CSR read-after-write hazards.
- Holds CSR write data until ROB retirement, then commits each write to the CSR regfile in order.

Parameters:
- DEPTH, 4, entry count; power of two, at least 2.
- IDX_WTH, $clog2(DEPTH), entry index width.
- DWTH, 64, CSR data width.
- CADDR_WTH, 12, CSR address width.
- PREG_WTH, 7, physical register index width.
- N_AWAKE, 5, number of wakeup channels.
- PLD_WTH, 32, width of the opaque payload carried to issue.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  pipeline flush
- dis_vld_i  in  1  dispatch valid
- dis_rdy_o  out  1  queue can accept
- dis_addr_i  in  CADDR_WTH  CSR address
- dis_rd_en_i  in  1  op reads the CSR
- dis_wr_en_i  in  1  op writes the CSR
- dis_rs1_idx_i  in  PREG_WTH  physical rs1
- dis_rs1_rdy_i  in  1  rs1 ready at dispatch
- dis_pld_i  in  PLD_WTH  opaque payload
- awake_vld_i  in  N_AWAKE  wakeup valid per channel
- awake_idx_i  in  N_AWAKE*PREG_WTH  wakeup register, channel k at bits [k*PREG_WTH +: PREG_WTH]
- awake_is_fp_i  in  N_AWAKE  wakeup targets the FP file; such a wakeup is ignored
- issue_vld_o  out  1  head-of-issue ready
- issue_rdy_i  in  1  execute accepts
- issue_idx_o  out  IDX_WTH  issued entry index
- issue_addr_o  out  CADDR_WTH  CSR address of issued entry
- issue_pld_o  out  PLD_WTH  payload of issued entry
- wd_en_i  in  1  write-data return
- wd_idx_i  in  IDX_WTH  entry for write data
- wd_data_i  in  DWTH  write data
- retire_i  in  1  ROB retires oldest CSR op
- rf_wr_en_o  out  1  regfile write
- rf_waddr_o  out  CADDR_WTH  regfile address
- rf_wdata_o  out  DWTH  regfile data
- cnt_o  out  IDX_WTH+1  occupancy
- err_o  out  1  sticky protocol error

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state: all pointers and flags zero; every entry's valid, rs1_rdy, raw_en and wd_vld zero.
- Outputs at reset: issue_vld_o=0, rf_wr_en_o=0, cnt_o=0, err_o=0, dis_rdy_o=1.
- Pointers: three circular pointers {flag,idx} for ins, iss and del.
  - full = ({~del_flag,del_idx} == ins).
  - empty = (del == ins).
  - issue-empty = (iss == ins).
  - Wrap-around toggles the flag.
  - cnt_o = ins - del, modulo 2*DEPTH.
- Backpressure: dis_rdy_o = ~full, from registered state only. A retire in the same cycle does not free a slot until the next cycle.
- Insert: on dis_vld_i && dis_rdy_o, entry[ins] captures address, rd/wr enables, rs1 index and payload; wd_vld is cleared.
  - rs1_rdy = dis_rs1_rdy_i OR any valid, non-FP wakeup this cycle matching dis_rs1_idx_i, so a same-cycle wakeup is not lost.
- Wakeup: each occupied entry sets rs1_rdy when any channel matches; all channels are OR-ed.
- RAW check at insert, only when dis_rd_en_i=1:
  - Scan occupied entries from del up to ins-1 for the youngest with wr_en and an equal address.
  - Exclude the entry being committed this cycle (rf_wr_en_o && index == del_idx).
  - On a hit: raw_en=1, raw_idx = that entry.
- RAW release: when rf_wr_en_o commits entry d, every entry with raw_en && raw_idx==d clears raw_en the next cycle.
- Issue:
  - issue_vld_o = !issue-empty && rs1_rdy[iss] && !raw_en[iss] && !flush_i.
  - Fields are combinational from entry[iss], with zero added latency.
  - iss advances on issue_vld_o && issue_rdy_i.
- Write data: wd_en_i writes wdata[wd_idx_i] and sets wd_vld. The last write in a cycle wins, and a write to an unoccupied entry sets err_o.
- Commit:
  - On retire_i: rf_wr_en_o = wr_en[del], rf_waddr_o = addr[del], rf_wdata_o = wdata[del], all combinational in the same cycle; del advances.
  - Retire when empty, when del==iss (not yet issued), or when wr_en && !wd_vld → set err_o and drop it.
- Flush: ins, iss and del return to zero; all entries are invalidated, raw_en cleared, err_o held.
  - Flush has priority over insert and issue.
  - A retire in the flush cycle still commits to the regfile.
- Simultaneous insert and retire: both pointers advance and cnt_o is unchanged.

Optional Feature:
- Macro: SY_CSR_IQ_BYPASS_EN.
- Enabled:
  - A RAW-blocked entry may issue once its producer's wd_vld=1.
  - Extra ports issue_fwd_vld_o and issue_fwd_data_o (DWTH) carry the producer's wdata.
  - The release-on-commit rule still applies.
- Disabled: the extra ports are absent, and an entry waits for producer commit.

Decomposition:
- sy_pkg holds the CSR_IQ_DEPTH and CSR_IQ_N_AWAKE defaults and the csr_iq_ent_t typedef (addr, rd_en, wr_en, rs1_idx, rs1_rdy, raw_en, raw_idx, wd_vld, pld).
- One sub-module, sy_ppl_csr_iq_wakeup: compares one rs1 index against N_AWAKE channels and returns a 1-bit match. It is instantiated DEPTH+1 times (one per entry plus one for the dispatch port).

Test Plan:
- Fill DEPTH=4 with rs1-ready non-RAW ops, no retire → dis_rdy_o=0 after the 4th insert, cnt_o=4; retire one → dis_rdy_o=1 the next cycle.
- Dispatch rs1=0x12 not ready while channel 3 wakes 0x12 in the same cycle → issue_vld_o=1 the next cycle; the same wakeup with awake_is_fp_i=1 → stays blocked.
- Write to 0x300 at entry 0, read of 0x300 at entry 1; issue entry 0, wd_data 0xABCD, retire → rf write 0x300/0xABCD and entry 1 issues one cycle later. With SY_CSR_IQ_BYPASS_EN, entry 1 issues right after wd_en with fwd_data 0xABCD.
- Run 10 insert/issue/retire rounds on DEPTH=4 → pointer wrap is clean, flags toggle, no err_o.
- Flush with 3 entries and a same-cycle retire of a write → regfile is written, cnt_o=0 and issue_vld_o=0 the next cycle.
- Retire while empty, or a write retired with no write data → err_o=1 and no regfile write.
